ca_step_ctrl: RTL
=================

Name: ca_step_ctrl

Overview:
- Sequencer for the 4x4-bit cell register bank: one write port (enable, 2-bit nibble select, 4-bit data) and four nibble outputs.
- The bank holds a 16-cell 1D cellular automaton.
- In IDLE/DONE, user nibble writes pass through to the bank; this is how the seed is loaded.
- In RUN, the block reads the bank, computes the next generation from an 8-bit Wolfram rule, and writes it back nibble by nibble.

Parameters:
- STEP_DIV, 4, clock cycles spent in WAIT before each generation (>=1).
- MAX_GEN, 16, generations per run; 0 = unlimited.
- GEN_W, 8, width of gen_count.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- user_wr  in  1  user nibble-write strobe
- user_sel  in  2  user nibble index
- user_data  in  4  user nibble value
- start  in  1  begin run (pulse)
- stop  in  1  request halt (pulse)
- rule  in  8  Wolfram rule number, sampled in SNAP
- bank_q  in  16  bank contents {in3,in2,in1,in0}; bit 15 = leftmost cell
- bank_en  out  1  bank write enable
- bank_sel  out  2  bank nibble select
- bank_d  out  4  bank write data
- busy  out  1  high in WAIT/SNAP/WRITE
- done  out  1  high in DONE
- gen_count  out  GEN_W  generations completed this run

Interface: reset reset, synchronous, active-high; clock clk.

Behaviour:
- States: IDLE, WAIT, SNAP, WRITE, DONE.
- Reset values: state=IDLE, gen_count=0, div counter=0, nib=0, stop_pend=0, snapshot=0, next=0, busy=0, done=0.
- Bank port in IDLE/DONE: bank_en=user_wr, bank_sel=user_sel, bank_d=user_data, combinational pass-through.
- Bank port in WAIT/SNAP: bank_en=0, bank_sel=0, bank_d=0.
- Bank port in WRITE: bank_en=1, bank_sel=nib, bank_d=next[4*nib+:4].
- IDLE/DONE + start: gen_count<=0, div<=0, go to WAIT. user_wr in the same cycle still passes through.
- WAIT: div increments; when div==STEP_DIV-1, go to SNAP and clear div.
- SNAP (1 cycle):
  - snapshot<=bank_q.
  - next[i]<=rule[{L,C,R}], with C=bank_q[i], L=bank_q[i+1], R=bank_q[i-1].
  - Periodic wrap: L of cell 15 is cell 0; R of cell 0 is cell 15.
  - nib<=0, go to WRITE.
- WRITE (exactly 4 cycles, nib 0..3):
  - All four nibbles come from the SNAP result; writeback never sees partially written state.
  - On nib==3: gen_count<=gen_count+1. Then:
    - stop_pend set -> IDLE, clear stop_pend.
    - MAX_GEN!=0 and gen_count+1==MAX_GEN -> DONE.
    - Otherwise -> WAIT.
- Generation period: STEP_DIV+5 cycles.
- stop:
  - In WAIT or SNAP: go to IDLE next cycle, no writes issued.
  - In WRITE: set stop_pend. The generation completes all 4 writes, then goes to IDLE. No torn generation.
  - Ignored in IDLE/DONE.
- start while busy: ignored. start and stop in the same cycle in IDLE: start wins. stop in the same cycle as start is ignored.
- user_wr while busy: ignored (never reaches the bank).
- gen_count: with MAX_GEN=0 it wraps modulo 2^GEN_W. It holds its value in IDLE/DONE until the next start.
- reset mid-WRITE: IDLE next cycle, bank_en=0. Bank contents are whatever was written before reset (the bank has its own reset).
- rule changes are seen only at SNAP.

Optional Feature:
- Macro: CA_NULL_BOUNDARY_EN.
- Defined: L of cell 15 and R of cell 0 are constant 0 (null boundary).
- Undefined: periodic wrap as above.
- Only the neighbour mux in ca_next_gen changes; timing is identical.

Decomposition:
- ca_pkg:
  - state enum (IDLE, WAIT, SNAP, WRITE, DONE).
  - NIB_W=4, NUM_NIB=4, CELLS=16.
  - Typedef cells_t = logic [15:0].
- Sub-module ca_next_gen: combinational; inputs cells_t and rule[7:0]; output cells_t. Holds the boundary macro. Instantiated once, output registered in SNAP.

Test Plan:
- Load via pass-through: user writes nibbles 1,0,0,0 to sel 0..3 in IDLE -> bank_en pulses each cycle; bank_q=0x0001.
- Rule 90, seed 0x0001, MAX_GEN=1, STEP_DIV=4, start -> WRITE issues sel 0,1,2,3 with data 2,0,0,8; bank_q=0x8002; done=1 and gen_count=1 at 10 cycles after start.
- Same with CA_NULL_BOUNDARY_EN -> bank_q=0x0002.
- Rule 204 (identity), seed 0xA5C3, MAX_GEN=3 -> bank_q stays 0xA5C3; gen_count=3; DONE after 27 cycles.
- stop asserted on the 2nd WRITE cycle with rule 0, seed 0xFFFF -> remaining nibbles still written; bank_q=0x0000; IDLE; gen_count=1.
- user_wr sel=2 data=F during WAIT -> bank_en stays 0; bank unchanged. reset during WRITE -> IDLE, busy=0, gen_count=0 next cycle.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types for the 16-cell cellular-automaton sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package ca_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int CELLS   = 16;

    typedef logic [CELLS-1:0] cells_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SNAP,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ca_next_gen.sv
// Next-generation rule lookup for 16 cells; CA_NULL_BOUNDARY_EN selects a null edge instead of wrap.
// Latency: combinational.
// Backpressure: none.
module ca_next_gen
    import ca_pkg::*;
(
    input  cells_t     cells,
    input  logic [7:0] rule,
    output cells_t     next
);

    // Left neighbour of cell i is cell i+1, right neighbour is cell i-1.
    cells_t left;
    cells_t right;

`ifdef CA_NULL_BOUNDARY_EN
    assign left  = {1'b0, cells[CELLS-1:1]};
    assign right = {cells[CELLS-2:0], 1'b0};
`else
    assign left  = {cells[0], cells[CELLS-1:1]};
    assign right = {cells[CELLS-2:0], cells[CELLS-1]};
`endif

    // Each cell indexes the rule byte with its {L,C,R} neighbourhood.
    always_comb begin
        next = '0;
        for (int i = 0; i < CELLS; i++) begin
            next[i] = rule[{left[i], cells[i], right[i]}];
        end
    end

endmodule

// File: rtl/ca_step_ctrl.sv
// Steps a 16-cell automaton held in an external 4x4-bit bank: wait, compute, write back 4 nibbles.
// Latency: one generation every STEP_DIV+5 cycles; user writes pass straight through when idle/done.
// Backpressure: none; stop during writeback is deferred until the generation is fully written.
module ca_step_ctrl
    import ca_pkg::*;
#(
    parameter int STEP_DIV = 4,
    parameter int MAX_GEN  = 16,
    parameter int GEN_W    = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             user_wr,
    input  logic [1:0]       user_sel,
    input  logic [3:0]       user_data,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       rule,
    input  logic [15:0]      bank_q,
    output logic             bank_en,
    output logic [1:0]       bank_sel,
    output logic [3:0]       bank_d,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int                DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [GEN_W-1:0]  GEN_LAST = GEN_W'(MAX_GEN);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic [1:0]       nib;
    logic             stop_pend;
    cells_t           next_gen;
    cells_t           next_comb;
    logic [GEN_W-1:0] gen_inc;

    // The bank image is only needed to form its successor, so SNAP captures
    // the successor directly; writeback then reads this frozen copy and never
    // sees its own partial writes.
    ca_next_gen u_next_gen (
        .cells (bank_q),
        .rule  (rule),
        .next  (next_comb)
    );

    assign gen_inc = gen_count + GEN_W'(1);

    // State register and per-state datapath updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div       <= '0;
            nib       <= '0;
            stop_pend <= 1'b0;
            next_gen  <= '0;
            gen_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        gen_count <= '0;
                        div       <= '0;
                        stop_pend <= 1'b0;
                    end
                end
                WAIT: begin
                    div <= (div == DIV_LAST || stop) ? '0 : div + DIV_W'(1);
                end
                SNAP: begin
                    next_gen <= next_comb;
                    nib      <= '0;
                end
                WRITE: begin
                    nib <= nib + 2'd1;
                    if (nib == 2'd3) begin
                        gen_count <= gen_inc;
                        stop_pend <= 1'b0;
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and bank-port steering; idle states hand the port to the user.
    always_comb begin
        state_nxt = state;
        bank_en   = 1'b0;
        bank_sel  = '0;
        bank_d    = '0;
        case (state)
            IDLE, DONE: begin
                bank_en  = user_wr;
                bank_sel = user_sel;
                bank_d   = user_data;
                if (start) state_nxt = WAIT;
            end
            WAIT: begin
                if (stop)                 state_nxt = IDLE;
                else if (div == DIV_LAST) state_nxt = SNAP;
            end
            SNAP: begin
                state_nxt = stop ? IDLE : WRITE;
            end
            WRITE: begin
                bank_en  = 1'b1;
                bank_sel = nib;
                bank_d   = next_gen[{nib, 2'b00} +: NIB_W];
                if (nib == 2'd3) begin
                    // A stop landing on the last nibble still finishes this generation.
                    if (stop_pend || stop)                      state_nxt = IDLE;
                    else if (MAX_GEN != 0 && gen_inc == GEN_LAST) state_nxt = DONE;
                    else                                        state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT) || (state == SNAP) || (state == WRITE);
    assign done = (state == DONE);

endmodule
